// File: rtl/floating_point_adder_pkg.sv
// Shared floating-point definitions for the adder and multiplier datapaths.
// Holds the exception-flag bundle plus format constants and field helpers.
// A package cannot be parameterised, so every helper takes the exponent and
// fraction widths as arguments. Operands are passed zero-extended to 64 bits,
// which covers every format up to binary64.
package floating_point_adder_pkg;

  // Exception flags reported alongside every registered result.
  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
  } fp_flags_t;

  localparam fp_flags_t FP_FLAGS_NONE = '{invalid: 1'b0, overflow: 1'b0, underflow: 1'b0};

  function automatic logic [63:0] ones_mask(input int n);
    return (64'd1 << n) - 64'd1;
  endfunction

  function automatic logic [63:0] bias(input int ew);
    return ones_mask(ew - 1);
  endfunction

  function automatic logic [63:0] exp_ones(input int ew);
    return ones_mask(ew);
  endfunction

  // Positive infinity: exponent all ones, fraction zero.
  function automatic logic [63:0] inf_bits(input int ew, input int mw);
    return ones_mask(ew) << mw;
  endfunction

  // Canonical quiet NaN: sign set, exponent all ones, fraction MSB only.
  function automatic logic [63:0] qnan_bits(input int ew, input int mw);
    return (64'd1 << (ew + mw)) | (ones_mask(ew) << mw) | (64'd1 << (mw - 1));
  endfunction

  function automatic logic [63:0] exp_of(input logic [63:0] op, input int ew, input int mw);
    return (op >> mw) & ones_mask(ew);
  endfunction

  function automatic logic [63:0] frac_of(input logic [63:0] op, input int mw);
    return op & ones_mask(mw);
  endfunction

  function automatic logic is_nan(input logic [63:0] op, input int ew, input int mw);
    return (exp_of(op, ew, mw) == ones_mask(ew)) && (frac_of(op, mw) != 64'd0);
  endfunction

  // Signalling NaN: NaN whose fraction MSB (the quiet bit) is clear.
  function automatic logic is_snan(input logic [63:0] op, input int ew, input int mw);
    return is_nan(op, ew, mw) && ((frac_of(op, mw) >> (mw - 1)) == 64'd0);
  endfunction

  function automatic logic is_inf(input logic [63:0] op, input int ew, input int mw);
    return (exp_of(op, ew, mw) == ones_mask(ew)) && (frac_of(op, mw) == 64'd0);
  endfunction

  function automatic logic is_zero(input logic [63:0] op, input int ew, input int mw);
    return (exp_of(op, ew, mw) == 64'd0) && (frac_of(op, mw) == 64'd0);
  endfunction

endpackage

// File: rtl/floating_point_adder_leading_zero_counter.sv
// Leading-zero counter over the normalization vector.
// Ports:
//   vec_i   : vector to scan, MSB first
//   count_o : number of zero bits above the most significant one
//             (equals Width when vec_i is all zeros)
module floating_point_adder_leading_zero_counter #(
  parameter int Width      = 27,
  parameter int CountWidth = $clog2(Width + 1)
) (
  input  logic [Width-1:0]      vec_i,
  output logic [CountWidth-1:0] count_o
);

  // Scan from the LSB up so the highest set bit writes the count last.
  always_comb begin
    count_o = CountWidth'(Width);
    for (int i = 0; i < Width; i++) begin
      count_o = vec_i[i] ? CountWidth'(Width - 1 - i) : count_o;
    end
  end

endmodule

// File: rtl/floating_point_adder.sv
// IEEE-754-style floating-point adder/subtractor with a registered result.
// Arithmetic is fully combinational; result and flags update on the clk edge.
// Ports:
//   clk, rst               : clock and synchronous active-high reset
//   a, b                   : operands {sign, exponent, fraction}
//   subtract               : 1 computes a - b, 0 computes a + b
//   out                    : registered result
//   underflow_flag         : registered, result is subnormal and nonzero
//   overflow_flag          : registered, result is infinite
//   invalid_operation_flag : registered, NaN input or inf - inf
module floating_point_adder
  import floating_point_adder_pkg::*;
#(
  parameter int ExponentWidth = 8,
  parameter int MantissaWidth = 23
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [ExponentWidth+MantissaWidth:0] a,
  input  logic [ExponentWidth+MantissaWidth:0] b,
  input  logic                                 subtract,
  output logic [ExponentWidth+MantissaWidth:0] out,
  output logic                                 underflow_flag,
  output logic                                 overflow_flag,
  output logic                                 invalid_operation_flag
);

  localparam int E   = ExponentWidth;
  localparam int M   = MantissaWidth;
  localparam int W   = 1 + E + M;
  localparam int SW  = M + 4;   // hidden + fraction + guard/round/sticky
  localparam int NW  = SW + 1;  // plus carry-out of the addition
  localparam int XW  = E + 2;   // exponent with headroom for carry/overflow
  localparam int MW2 = M + 2;   // rounded significand plus carry
  localparam int CW  = $clog2(SW + 1);

  localparam logic [W-1:0]  QNAN    = W'(qnan_bits(E, M));
  localparam logic [W-1:0]  POS_INF = W'(inf_bits(E, M));
  localparam logic [XW-1:0] EXP_MAX = XW'(exp_ones(E));

  logic            sa_s, sb_s;
  logic            nan_a_s, nan_b_s, inf_a_s, inf_b_s, zero_a_s, zero_b_s;
  logic            l_sign_s, s_sign_s;
  logic [E-1:0]    l_exp_s, s_exp_s, l_eexp_s, s_eexp_s, diff_s;
  logic [M-1:0]    l_frac_s, s_frac_s;
  logic [M:0]      l_sig_s, s_sig_s;
  logic [2*SW-1:0] wide_s;
  logic [SW-1:0]   aligned_s, l_ext_s;
  logic            sticky_s;
  logic [NW-1:0]   sum_s;
  logic [CW-1:0]   lz_s;
  logic [XW-1:0]   e0_s, e1_s, e2_s, shamt_s;
  logic [SW-1:0]   norm_s;
  logic            rnd_up_s;
  logic [MW2-1:0]  mant_s;
  logic [M-1:0]    frac_s;

  logic [W-1:0]    out_d, out_q;
  fp_flags_t       flags_d, flags_q;

  // Operand classification with the effective sign of b.
  always_comb begin
    sa_s     = a[W-1];
    sb_s     = b[W-1] ^ subtract;
    nan_a_s  = is_nan(64'(a), E, M);
    nan_b_s  = is_nan(64'(b), E, M);
    inf_a_s  = is_inf(64'(a), E, M);
    inf_b_s  = is_inf(64'(b), E, M);
    zero_a_s = is_zero(64'(a), E, M);
    zero_b_s = is_zero(64'(b), E, M);
  end

  // Order by magnitude and right-align the smaller significand with sticky.
  always_comb begin
    if (a[W-2:0] >= b[W-2:0]) begin
      l_sign_s = sa_s;       s_sign_s = sb_s;
      l_exp_s  = a[W-2:M];   s_exp_s  = b[W-2:M];
      l_frac_s = a[M-1:0];   s_frac_s = b[M-1:0];
    end else begin
      l_sign_s = sb_s;       s_sign_s = sa_s;
      l_exp_s  = b[W-2:M];   s_exp_s  = a[W-2:M];
      l_frac_s = b[M-1:0];   s_frac_s = a[M-1:0];
    end
    // Subnormals have a zero hidden bit and behave as exponent 1.
    l_eexp_s = (l_exp_s == {E{1'b0}}) ? {{(E-1){1'b0}}, 1'b1} : l_exp_s;
    s_eexp_s = (s_exp_s == {E{1'b0}}) ? {{(E-1){1'b0}}, 1'b1} : s_exp_s;
    l_sig_s  = {(l_exp_s != {E{1'b0}}), l_frac_s};
    s_sig_s  = {(s_exp_s != {E{1'b0}}), s_frac_s};
    diff_s   = l_eexp_s - s_eexp_s;
    l_ext_s  = {l_sig_s, 3'b000};
    wide_s   = {s_sig_s, 3'b000, {SW{1'b0}}} >> diff_s;
    if (32'(diff_s) >= 32'(SW)) begin
      aligned_s = {SW{1'b0}};
      sticky_s  = |s_sig_s;
    end else begin
      aligned_s = wide_s[2*SW-1:SW];
      sticky_s  = |wide_s[SW-1:0];
    end
    aligned_s[0] = aligned_s[0] | sticky_s;
  end

  // Magnitude add or subtract; larger minus smaller never goes negative.
  always_comb begin
    if (l_sign_s == s_sign_s) begin
      sum_s = {1'b0, l_ext_s} + {1'b0, aligned_s};
    end else begin
      sum_s = {1'b0, l_ext_s} - {1'b0, aligned_s};
    end
  end

  floating_point_adder_leading_zero_counter #(
    .Width      (SW),
    .CountWidth (CW)
  ) u_lzc (
    .vec_i   (sum_s[SW-1:0]),
    .count_o (lz_s)
  );

  // Normalize; the left shift is capped so the exponent never drops below 1.
  always_comb begin
    e0_s    = XW'(l_eexp_s);
    shamt_s = {XW{1'b0}};
    if (sum_s[NW-1]) begin
      norm_s = {sum_s[NW-1:2], sum_s[1] | sum_s[0]};
      e1_s   = e0_s + {{(XW-1){1'b0}}, 1'b1};
    end else begin
      shamt_s = (XW'(lz_s) < (e0_s - {{(XW-1){1'b0}}, 1'b1})) ?
                XW'(lz_s) : (e0_s - {{(XW-1){1'b0}}, 1'b1});
      norm_s  = sum_s[SW-1:0] << shamt_s;
      e1_s    = e0_s - shamt_s;
    end
  end

  // Round to nearest even; a zero hidden bit after rounding means subnormal.
  always_comb begin
    rnd_up_s = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
    mant_s   = {1'b0, norm_s[SW-1:3]} + MW2'(rnd_up_s);
    if (mant_s[M+1]) begin
      e2_s   = e1_s + {{(XW-1){1'b0}}, 1'b1};
      frac_s = mant_s[M:1];
    end else if (mant_s[M]) begin
      e2_s   = e1_s;
      frac_s = mant_s[M-1:0];
    end else begin
      e2_s   = {XW{1'b0}};
      frac_s = mant_s[M-1:0];
    end
  end

  // Result selection: special operands in priority order, then finite path.
  always_comb begin
    out_d   = {W{1'b0}};
    flags_d = FP_FLAGS_NONE;
    if (nan_a_s || nan_b_s) begin
      out_d           = QNAN;
      flags_d.invalid = 1'b1;
    end else if (inf_a_s && inf_b_s && (sa_s != sb_s)) begin
      out_d           = QNAN;
      flags_d.invalid = 1'b1;
    end else if (inf_a_s) begin
      out_d            = {sa_s, POS_INF[W-2:0]};
      flags_d.overflow = 1'b1;
    end else if (inf_b_s) begin
      out_d            = {sb_s, POS_INF[W-2:0]};
      flags_d.overflow = 1'b1;
    end else if (zero_a_s && zero_b_s) begin
      out_d = {sa_s & sb_s, {(W-1){1'b0}}};
    end else if (zero_a_s) begin
      out_d = {sb_s, b[W-2:0]};
    end else if (zero_b_s) begin
      out_d = a;
    end else if (sum_s == {NW{1'b0}}) begin
      out_d = {W{1'b0}};  // exact cancellation is +0
    end else if (e2_s >= EXP_MAX) begin
      out_d            = {l_sign_s, POS_INF[W-2:0]};
      flags_d.overflow = 1'b1;
    end else begin
      out_d             = {l_sign_s, e2_s[E-1:0], frac_s};
      flags_d.underflow = (e2_s == {XW{1'b0}}) && (frac_s != {M{1'b0}});
    end
  end

  // Result and flag registers; reset wins over the sampled operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= {W{1'b0}};
      flags_q <= FP_FLAGS_NONE;
    end else begin
      out_q   <= out_d;
      flags_q <= flags_d;
    end
  end

  assign out                    = out_q;
  assign underflow_flag         = flags_q.underflow;
  assign overflow_flag          = flags_q.overflow;
  assign invalid_operation_flag = flags_q.invalid;

endmodule

// File: tb/tb_floating_point_adder.sv
module tb_floating_point_adder;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] exp_out;
    logic        exp_uf;
    logic        exp_of;
    logic        exp_inv;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic        subtract;
  logic [31:0] out;
  logic        underflow_flag;
  logic        overflow_flag;
  logic        invalid_operation_flag;

  int applied;
  int miscompares;

  vec_t vecs[23];

  floating_point_adder #(
    .ExponentWidth (8),
    .MantissaWidth (23)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .a                      (a),
    .b                      (b),
    .subtract               (subtract),
    .out                    (out),
    .underflow_flag         (underflow_flag),
    .overflow_flag          (overflow_flag),
    .invalid_operation_flag (invalid_operation_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] eo,
                       input logic euf, input logic eof, input logic einv);
    applied++;
    if (out !== eo || underflow_flag !== euf || overflow_flag !== eof ||
        invalid_operation_flag !== einv) begin
      miscompares++;
      $display("FAIL %s: got out=%08h uf=%0b of=%0b inv=%0b, expected out=%08h uf=%0b of=%0b inv=%0b",
               name, out, underflow_flag, overflow_flag, invalid_operation_flag,
               eo, euf, eof, einv);
    end
  endtask

  // Drive away from the active edge, clock once, sample 1 time unit later.
  task automatic apply(input vec_t v);
    @(negedge clk);
    a        = v.a;
    b        = v.b;
    subtract = v.sub;
    @(posedge clk);
    #1;
    check(v.name, v.exp_out, v.exp_uf, v.exp_of, v.exp_inv);
  endtask

  initial begin
    applied     = 0;
    miscompares = 0;

    //          name            a             b             sub   out           uf    of    inv
    vecs[0]  = '{"add_3_4",      32'h40400000, 32'h40800000, 1'b0, 32'h40E00000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{"add_8p7_0p3",  32'h410B3333, 32'h3E99999A, 1'b0, 32'h41100000, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{"add_big_small",32'h469C4600, 32'h3DCCCCCD, 1'b0, 32'h469C4633, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{"add_tiny_big", 32'h38D1B717, 32'h3F6E147B, 1'b0, 32'h3F6E1B09, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{"inf_plus_3",   32'h7F800000, 32'h40400000, 1'b0, 32'h7F800000, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{"inf_plus_inf", 32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{"ninf_pl_ninf", 32'hFF800000, 32'hFF800000, 1'b0, 32'hFF800000, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{"ninf_pl_inf",  32'hFF800000, 32'h7F800000, 1'b0, 32'hFFC00000, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{"inf_min_inf",  32'h7F800000, 32'h7F800000, 1'b1, 32'hFFC00000, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{"qnan_plus_0",  32'hFFC00000, 32'h00000000, 1'b0, 32'hFFC00000, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{"snan_plus_0",  32'hFFA00000, 32'h00000000, 1'b0, 32'hFFC00000, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{"zero_plus_3",  32'h00000000, 32'h40400000, 1'b0, 32'h40400000, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{"x_plus_zero",  32'h42F00000, 32'h00000000, 1'b0, 32'h42F00000, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{"pz_plus_nz",   32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{"cancel_3",     32'h40400000, 32'h40400000, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{"max_plus_max", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{"min_sub_half", 32'h00800000, 32'h00400000, 1'b1, 32'h00400000, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{"3_minus_n4",   32'h40400000, 32'hC0800000, 1'b1, 32'h40E00000, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{"subn_to_norm", 32'h007FFFFF, 32'h00000001, 1'b0, 32'h00800000, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{"tie_even_dn",  32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b0};
    vecs[20] = '{"tie_even_up",  32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 1'b0, 1'b0, 1'b0};
    vecs[21] = '{"nz_plus_nz",   32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b0};
    vecs[22] = '{"zero_minus_3", 32'h00000000, 32'h40400000, 1'b1, 32'hC0400000, 1'b0, 1'b0, 1'b0};

    // Reset state.
    rst      = 1'b1;
    a        = 32'h00000000;
    b        = 32'h00000000;
    subtract = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_state", 32'h00000000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back table of vectors, one per cycle.
    for (int i = 0; i < 23; i++) begin
      apply(vecs[i]);
    end

    // Reset beats a live operation: load a nonzero result, then reset with
    // operands that would otherwise produce overflow.
    apply(vecs[0]);
    @(negedge clk);
    rst = 1'b1;
    a   = 32'h7F800000;
    b   = 32'h40400000;
    @(posedge clk);
    #1;
    check("reset_priority", 32'h00000000, 1'b0, 1'b0, 1'b0);

    // Operation resumes on the first cycle after reset drops, and flags
    // clear once a normal result follows an exceptional one.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("after_reset", 32'h7F800000, 1'b0, 1'b1, 1'b0);
    apply(vecs[16]);
    apply(vecs[1]);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
